// File: rtl/cache_data_pkg.sv
// Shared types and constants for the cache data SRAM controller.
// Geometry: 32 sets x 256-bit lines, filled as 4 x 64-bit beats.
package cache_data_pkg;

  localparam int NUM_SETS  = 32;
  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
  localparam int MASK_W    = LINE_BITS / 8;
  localparam int BEAT_W    = $clog2(BEATS);

  typedef logic [SET_W-1:0]     set_idx_t;
  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [MASK_W-1:0]    line_mask_t;
  typedef logic [BEAT_BITS-1:0] beat_t;
  typedef logic [BEAT_W-1:0]    beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } dsram_state_e;

  // Byte-enable lane for fill beat k.
  function automatic line_mask_t beat_mask(input beat_idx_t k);
    line_mask_t m;
    m = '0;
    m[k*(BEAT_BITS/8) +: BEAT_BITS/8] = '1;
    return m;
  endfunction

endpackage

// File: rtl/cache_data_sram_ctrl_skid.sv
// Read response skid: SRAM dout is passed through the cycle after a read
// and captured into a hold register if the consumer is not ready.
module dsram_resp_skid
  import cache_data_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  rd_acc_i,
  input  line_t dout_i,
  input  logic  resp_ready_i,
  output logic  resp_valid_o,
  output line_t resp_rdata_o,
  output logic  stall_o
);

  logic  pend_q, pend_d;
  logic  hvld_q, hvld_d;
  line_t hold_q, hold_d;

  assign resp_valid_o = pend_q | hvld_q;
  assign resp_rdata_o = hvld_q ? hold_q : dout_i;
  assign stall_o      = resp_valid_o & ~resp_ready_i;

  always_comb begin
    pend_d = rd_acc_i;
    hvld_d = stall_o;
    hold_d = hold_q;
    // dout is only stable until the next SRAM capture
    if (pend_q && !hvld_q && !resp_ready_i) hold_d = dout_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      hvld_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hvld_q <= hvld_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/cache_data_sram_ctrl.sv
// Owner of the cache data SRAM RW port: CPU reads/masked writes, 4-beat
// line fills (fill has priority), skid-buffered read responses.
// Ports: req_* CPU request, resp_* read response, fill_* fill beats,
// sram_* SRAM macro pins (active-low csb/web).
// Option DSRAM_FILL_COLLAPSE_EN: stage beats 0-2, one full-line write on beat 3.
module cache_data_sram_ctrl
  import cache_data_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  set_idx_t   req_set,
  input  line_mask_t req_wmask,
  input  line_t      req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output line_t      resp_rdata,
  input  logic       fill_valid,
  output logic       fill_ready,
  input  set_idx_t   fill_set,
  input  beat_t      fill_data,
  output logic       fill_done,
  output logic       sram_csb,
  output logic       sram_web,
  output set_idx_t   sram_addr,
  output line_mask_t sram_wmask,
  output line_t      sram_din,
  input  line_t      sram_dout
);

  dsram_state_e state_q, state_d;
  beat_idx_t    beat_q, beat_d;
  set_idx_t     fset_q, fset_d;
  set_idx_t     addr_q, addr_d;
  line_mask_t   wmask_q, wmask_d;
  line_t        din_q, din_d;
  logic         done_q, done_d;

  logic       stall;
  logic       cpu_acc, fill_acc, fill_wr;
  set_idx_t   fill_addr;
  line_mask_t fill_mask;
  line_t      fill_line;

  assign cpu_acc   = rst_n & req_valid & req_ready;
  assign fill_acc  = rst_n & fill_valid & fill_ready;
  assign fill_addr = (beat_q == '0) ? fill_set : fset_q;

  dsram_resp_skid u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_acc_i     (cpu_acc & ~req_write),
    .dout_i       (sram_dout),
    .resp_ready_i (resp_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .stall_o      (stall)
  );

`ifdef DSRAM_FILL_COLLAPSE_EN
  logic [LINE_BITS-BEAT_BITS-1:0] stage_q, stage_d;

  // Shift in from the top so beat 0 ends up in the low lane.
  assign stage_d = (fill_acc && beat_q != LAST_BEAT)
                 ? {fill_data, stage_q[LINE_BITS-BEAT_BITS-1:BEAT_BITS]}
                 : stage_q;
  assign fill_wr   = fill_acc & (beat_q == LAST_BEAT);
  assign fill_mask = '1;
  assign fill_line = {fill_data, stage_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end
`else
  assign fill_wr   = fill_acc;
  assign fill_mask = beat_mask(beat_q);
  assign fill_line = {BEATS{fill_data}};
`endif

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a stalled response must be captured before the SRAM is reused
        fill_ready = ~stall;
        req_ready  = ~fill_valid & ~stall;
        if (fill_valid && !stall) state_d = FILL;
        else if (stall)           state_d = HOLD;
      end
      FILL: begin
        fill_ready = 1'b1;
        if (fill_valid && beat_q == LAST_BEAT) state_d = IDLE;
      end
      HOLD: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_d = fill_acc ? beat_q + 1'b1 : beat_q;
    fset_d = (fill_acc && beat_q == '0) ? fill_set : fset_q;
    done_d = fill_acc & (beat_q == LAST_BEAT);
  end

  always_comb begin
    sram_web = 1'b1;
    addr_d   = addr_q;
    wmask_d  = wmask_q;
    din_d    = din_q;
    unique case (1'b1)
      fill_wr: begin
        sram_web = 1'b0;
        addr_d   = fill_addr;
        wmask_d  = fill_mask;
        din_d    = fill_line;
      end
      cpu_acc: begin
        sram_web = ~req_write;
        addr_d   = req_set;
        wmask_d  = req_wmask;
        din_d    = req_wdata;
      end
      default: ;
    endcase
  end

  assign sram_csb   = ~(fill_wr | cpu_acc);
  assign sram_addr  = addr_d;
  assign sram_wmask = wmask_d;
  assign sram_din   = din_d;
  assign fill_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fset_q  <= '0;
      addr_q  <= '0;
      wmask_q <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fset_q  <= fset_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

endmodule
